// File: rtl/core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_pkg: shared constants and types for the hazard controller   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package core_pkg;

  localparam int REG_AW = 3;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STALL1 = 2'd1;
  localparam logic [1:0] ST_STALL2 = 2'd2;

  localparam logic CMP_SEL_RF  = 1'b1;
  localparam logic CMP_SEL_FWD = 1'b0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_scoreboard: EX/MEM shadow destination tracking + matching |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              bubble,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  output logic [1:0]        ex_hit,
  output logic [1:0]        mem_hit,
  output logic              ex_load,
  output logic              mem_load
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;

  function automatic logic src_hit(input logic en, input logic [REG_AW-1:0] src,
                                   input sb_entry_t e);
    return en && e.valid && e.regwrite && (src == e.rd) &&
           !(ZERO_HARDWIRED && (src == '0));
  endfunction

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (advance) begin
      mem_d = ex_q;
      ex_d  = '0;
      if (!bubble) begin
        ex_d.valid    = 1'b1;
        ex_d.rd       = id_rd;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  // bit 0 tracks rs1, bit 1 tracks rs2
  always_comb begin
    ex_hit[0]  = src_hit(id_use_rs1, id_rs1, ex_q);
    ex_hit[1]  = src_hit(id_use_rs2, id_rs2, ex_q);
    mem_hit[0] = src_hit(id_use_rs1, id_rs1, mem_q);
    mem_hit[1] = src_hit(id_use_rs2, id_rs2, mem_q);
    ex_load    = ex_q.memread;
    mem_load   = mem_q.memread;
  end

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_controller: stall FSM, flush and decode-compare forwarding |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module hazard_controller #(
  parameter int REG_AW         = 3,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_branch,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_jump,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_hold,
  output logic              cmp_sel1,
  output logic              cmp_sel2,
  output logic [1:0]        stall_state
);
  import core_pkg::*;

  logic [1:0] state_q, state_d;
  logic [1:0] stall_req;
  logic [1:0] eff_state;
  logic       stalled;
  logic [1:0] ex_hit, mem_hit;
  logic       ex_load, mem_load;

  hazard_scoreboard #(
    .ZERO_HARDWIRED (ZERO_HARDWIRED)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .advance     (!mem_busy),
    .bubble      (stalled),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .ex_hit      (ex_hit),
    .mem_hit     (mem_hit),
    .ex_load     (ex_load),
    .mem_load    (mem_load)
  );

  // Requirement is the total number of stall cycles, counting the current one.
  always_comb begin
    stall_req = ST_RUN;
    if (ex_load && (|ex_hit)) begin
      stall_req = id_is_branch ? ST_STALL2 : ST_STALL1;
    end else if (id_is_branch && ((|ex_hit) || (mem_load && (|mem_hit)))) begin
      stall_req = ST_STALL1;
    end
  end

  // A detected stall is entered in the detecting cycle; the register holds the remainder.
  always_comb begin
    eff_state = (state_q != ST_RUN) ? state_q : stall_req;
    stalled   = (eff_state != ST_RUN);
    state_d   = state_q;
    if (!mem_busy) begin
      state_d = (eff_state == ST_STALL2) ? ST_STALL1 : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
    end else if (stalled) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = id_jump;
    end
    cmp_sel1    = (id_is_branch && mem_hit[0] && !mem_load) ? CMP_SEL_FWD : CMP_SEL_RF;
    cmp_sel2    = (id_is_branch && mem_hit[1] && !mem_load) ? CMP_SEL_FWD : CMP_SEL_RF;
    stall_state = eff_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hazard_controller: directed scenarios plus randomized model   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_hazard_controller;

  logic       clk;
  logic       reset;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_is_branch;
  logic       id_regwrite, id_memread, id_jump, mem_busy;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;
  logic       cmp_sel1, cmp_sel2;
  logic [1:0] stall_state;
  logic [8:0] obs;

  int errors = 0;
  int checks = 0;

  hazard_controller #(
    .REG_AW         (3),
    .ZERO_HARDWIRED (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_is_branch (id_is_branch),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_jump      (id_jump),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_hold   (exmem_hold),
    .cmp_sel1     (cmp_sel1),
    .cmp_sel2     (cmp_sel2),
    .stall_state  (stall_state)
  );

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, cmp_sel1, cmp_sel2, stall_state}
  assign obs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold,
                cmp_sel1, cmp_sel2, stall_state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic [2:0] rs1, input logic [2:0] rs2, input logic u1,
                        input logic u2, input logic br, input logic [2:0] rd,
                        input logic rw, input logic mr, input logic jmp);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_is_branch = br; id_rd = rd; id_regwrite = rw; id_memread = mr; id_jump = jmp;
  endtask

  task automatic nop();
    set_id(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    mem_busy = 1'b0;
    nop();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    reset = 1'b0;
    mem_busy = 1'b0;
    nop();
    tick();
    #2;
    exp = 9'b110001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_outputs: obs=%b exp=%b", obs, exp); end
    set_id(3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
    tick();
    #2;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_hold: obs=%b exp=%b", obs, exp); end
    reset = 1'b1;
    nop();
    tick();
  endtask

  task automatic test_load_use();
    logic [8:0] exp;
    apply_reset();
    set_id(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
    #2;
    exp = 9'b110001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lu_load_issue: obs=%b exp=%b", obs, exp); end
    tick();
    set_id(3'd4, 3'd0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
    #2;
    exp = 9'b000101101;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lu_stall: obs=%b exp=%b", obs, exp); end
    tick();
    #2;
    exp = 9'b110001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lu_issue: obs=%b exp=%b", obs, exp); end
    tick();
    nop();
  endtask

  task automatic test_load_branch();
    logic [8:0] exp;
    apply_reset();
    set_id(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    #2;
    exp = 9'b000101110;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lb_stall2: obs=%b exp=%b", obs, exp); end
    tick();
    #2;
    exp = 9'b000101101;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lb_stall1: obs=%b exp=%b", obs, exp); end
    tick();
    #2;
    exp = 9'b111001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lb_release: obs=%b exp=%b", obs, exp); end
    tick();
    nop();
    #2;
    exp = 9'b110001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL lb_after: obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_alu_branch();
    logic [8:0] exp;
    apply_reset();
    set_id(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(3'd0, 3'd6, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    #2;
    exp = 9'b000101101;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_stall: obs=%b exp=%b", obs, exp); end
    tick();
    #2;
    exp = 9'b110001000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_forward: obs=%b exp=%b", obs, exp); end
    tick();
    nop();
    #2;
    exp = 9'b110001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_restore: obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_x0();
    logic [8:0] exp;
    apply_reset();
    set_id(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    #2;
    exp = 9'b110001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL x0_ex: obs=%b exp=%b", obs, exp); end
    tick();
    #2;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL x0_mem: obs=%b exp=%b", obs, exp); end
    tick();
    nop();
  endtask

  task automatic test_jump();
    logic [8:0] exp;
    apply_reset();
    set_id(3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    #2;
    exp = 9'b111001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL jmp_flush: obs=%b exp=%b", obs, exp); end
    tick();
    id_jump = 1'b0;
    #2;
    exp = 9'b110001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL jmp_single: obs=%b exp=%b", obs, exp); end
    tick();
    set_id(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    #2;
    exp = 9'b000101101;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL jmp_stalled: obs=%b exp=%b", obs, exp); end
    tick();
    #2;
    exp = 9'b111000100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL jmp_after_stall: obs=%b exp=%b", obs, exp); end
    tick();
    nop();
  endtask

  task automatic test_mem_busy();
    logic [8:0] exp;
    apply_reset();
    set_id(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    #2;
    exp = 9'b000101110;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mb_stall2: obs=%b exp=%b", obs, exp); end
    mem_busy = 1'b1;
    #1;
    exp = 9'b000011110;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mb_frozen%0d: obs=%b exp=%b", i, obs, exp); end
      tick();
      #2;
    end
    mem_busy = 1'b0;
    #1;
    exp = 9'b000101110;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mb_release: obs=%b exp=%b", obs, exp); end
    tick();
    #2;
    exp = 9'b000101101;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mb_stall1: obs=%b exp=%b", obs, exp); end
    tick();
    #2;
    exp = 9'b110001100;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mb_run: obs=%b exp=%b", obs, exp); end
    tick();
    set_id(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_mid_stall: obs=%b exp=%b", obs, exp); end
    tick();
    reset = 1'b1;
    #2;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_release: obs=%b exp=%b", obs, exp); end
    tick();
    nop();
  endtask

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       rw;
    logic       mr;
  } m_ent_t;

  // Model: a producer's value reaches the decode consumer once the producer has
  // advanced to a given stage (EX=1, MEM=2, WB=3); stall = stages still missing.
  task automatic test_random();
    m_ent_t     pipe [1:2];
    logic [2:0] src [0:1];
    logic       usr [0:1];
    logic       fwd [0:1];
    logic [2:0] rs1, rs2, rd;
    logic       u1, u2, br, rw, mr, jmp, busy, stl;
    logic       issue_new;
    logic [8:0] exp;
    int         need, ready, left, ss;
    apply_reset();
    pipe[1] = '0;
    pipe[2] = '0;
    left = 0;
    issue_new = 1'b1;
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; br = 0; rw = 0; mr = 0; jmp = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (issue_new) begin
        rs1 = 3'($urandom_range(0, 3));
        rs2 = 3'($urandom_range(0, 3));
        rd  = 3'($urandom_range(0, 3));
        u1  = 1'($urandom_range(0, 1));
        u2  = 1'($urandom_range(0, 1));
        br  = ($urandom_range(0, 2) == 0);
        rw  = 1'($urandom_range(0, 1));
        mr  = rw && ($urandom_range(0, 1) == 1);
        jmp = br && ($urandom_range(0, 1) == 1);
      end
      busy = ($urandom_range(0, 7) == 0);
      set_id(rs1, rs2, u1, u2, br, rd, rw, mr, jmp);
      mem_busy = busy;
      #2;
      src[0] = rs1; src[1] = rs2; usr[0] = u1; usr[1] = u2;
      fwd[0] = 1'b0; fwd[1] = 1'b0;
      need = 0;
      for (int s = 1; s <= 2; s++) begin
        for (int k = 0; k < 2; k++) begin
          if (usr[k] && pipe[s].v && pipe[s].rw && pipe[s].rd == src[k] && src[k] != 3'd0) begin
            ready = br ? (pipe[s].mr ? 3 : 2) : (pipe[s].mr ? 2 : 1);
            if (ready - s > need) need = ready - s;
            if (br && s == 2 && !pipe[s].mr) fwd[k] = 1'b1;
          end
        end
      end
      stl = (left > 0) || (need > 0);
      ss  = (left > 0) ? left : need;
      if (busy)     exp[8:4] = 5'b00001;
      else if (stl) exp[8:4] = 5'b00010;
      else          exp[8:4] = {2'b11, jmp, 2'b00};
      exp[3] = !fwd[0];
      exp[2] = !fwd[1];
      exp[1:0] = 2'(ss);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rand_cycle%0d: obs=%b exp=%b", cyc, obs, exp);
      end
      if (!busy) begin
        left = (left > 0) ? left - 1 : ((need > 0) ? need - 1 : 0);
        pipe[2] = pipe[1];
        pipe[1] = stl ? m_ent_t'('0) : m_ent_t'({1'b1, rd, rw, mr});
        issue_new = !stl;
      end else begin
        issue_new = 1'b0;
      end
      tick();
    end
    mem_busy = 1'b0;
    nop();
  endtask

  initial begin
    reset = 1'b0;
    mem_busy = 1'b0;
    nop();
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_x0();
    test_jump();
    test_mem_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 16-bit five-stage core.
- Tracks in-flight destination registers in EX and MEM with its own shadow scoreboard.
- Generates PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush.
- Drives the decode-stage comparator forwarding selects (comparatorMux1Control/comparatorMux2Control) for branch resolution in decode.

Parameters:
- REG_AW, 3: register address width (8 registers).
- ZERO_HARDWIRED, 1: when 1, register x0 never creates a hazard and is never forwarded.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_AW  source 1 of the instruction in decode.
- id_rs2  in  REG_AW  source 2 of the instruction in decode.
- id_use_rs1  in  1  decode instruction reads rs1.
- id_use_rs2  in  1  decode instruction reads rs2.
- id_is_branch  in  1  decode instruction compares operands in decode.
- id_rd  in  REG_AW  destination of the decode instruction.
- id_regwrite  in  1  RegWrite from decode.
- id_memread  in  1  MemRead from decode (load).
- id_jump  in  1  decode jump/branch taken (the decode jump output).
- mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID register loads a NOP.
- idex_bubble  out  1  ID/EX register loads all-zero control.
- exmem_hold  out  1  EX/MEM and MEM/WB hold.
- cmp_sel1  out  1  comparatorMux1Control: 1 selects the register file, 0 selects comparatorMuxForward (EX/MEM ALU result).
- cmp_sel2  out  1  comparatorMux2Control, same encoding.
- stall_state  out  2  FSM state, for debug.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to RUN; scoreboard cleared (ex_v, mem_v = 0).
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, exmem_hold=0, cmp_sel1=cmp_sel2=1, stall_state=0.
- Scoreboard:
  - Each stage holds {valid, rd, regwrite, memread}.
  - On an advancing edge, EX takes the decode fields, or zeros if idex_bubble is set; MEM takes EX.
  - With mem_busy=1 the scoreboard holds.
- Match definition: match(src, stage) = use && stage.valid && stage.regwrite && src==stage.rd && !(ZERO_HARDWIRED && src==0).
- Stall requirement, computed combinationally in RUN:
  - Load in EX matching any used source: 1 cycle, but 2 cycles if id_is_branch.
  - ALU op in EX matching a branch source: 1 cycle.
  - Load in MEM matching a branch source: 1 cycle.
  - Otherwise 0.
- FSM states: RUN=0, STALL1=1, STALL2=2.
  - RUN with requirement 2 goes to STALL2; requirement 1 goes to STALL1; otherwise stays in RUN.
  - STALL2 goes to STALL1; STALL1 goes to RUN.
  - Matches are re-evaluated every cycle: leaving STALL1 with a residual match re-enters a stall. No deadlock, because bubbles drain EX.
- Outputs while stalled:
  - Any cycle where the requirement is nonzero or the state is not RUN: pc_write=0, ifid_write=0, idex_bubble=1.
  - The decode instruction is held and re-evaluated next cycle.
- Forwarding: cmp_sel{1,2}=0 when a branch source matches a non-load ALU op in MEM; otherwise 1.
- Writeback-stage matches: resolved by the register file's write-before-read; no action here.
- Jump flush: id_jump=1 with no stall and mem_busy=0 gives ifid_flush=1 for exactly that cycle.
  - id_jump is ignored while stalled; the branch is resolved only once its operands are valid.
- mem_busy=1 has priority over everything:
  - pc_write=0, ifid_write=0, exmem_hold=1, idex_bubble=0, ifid_flush=0.
  - FSM and scoreboard frozen; stall counts resume after mem_busy falls.
- Reset mid-stall aborts to RUN immediately; no stale scoreboard entry survives.
- Latency: all outputs are combinational from inputs plus registered state; no pipeline latency is added.

Decomposition:
- Shared package `core_pkg`:
  - FSM state encoding localparams (RUN/STALL1/STALL2).
  - REG_AW.
  - The CMP_SEL_RF=1 / CMP_SEL_FWD=0 constants.
  - The scoreboard entry struct {valid, rd, regwrite, memread}.
- One natural sub-module: `hazard_scoreboard` (the EX/MEM shadow shift register plus match logic). The FSM and output decode stay in the top level.

Test Plan:
- Load then use: `lw x4` (id_memread=1, rd=4), next decode ALU op with rs1=4 → exactly 1 cycle of pc_write=0, idex_bubble=1; the ALU op issues on the next cycle.
- Load then branch: `lw x5`, next a branch on x5 → 2 stall cycles (stall_state 2 then 1), then cmp_sel1=1 (register-file path) and jump is honoured.
- ALU op then branch: `add x6` followed by a branch with rs2=6:
  - 1 stall cycle, with cmp_sel2=1 during it.
  - Next cycle cmp_sel2=0 (forward from MEM).
  - Following cycle cmp_sel2 returns to 1.
- x0 destination: ALU op with rd=0 followed by a branch on x0 → no stall, cmp_sel1=cmp_sel2=1.
- Taken jump: id_jump=1 with no hazard → ifid_flush=1 for one cycle, pc_write=1; with a hazard present, ifid_flush stays 0 until the stall ends.
- mem_busy during STALL2: assert mem_busy for 3 cycles → state stays 2, exmem_hold=1. Releasing it gives STALL1, then RUN. Driving reset low mid-stall → immediate RUN with pc_write=1.
